// File: rtl/scarv_cop_pkg.sv
// Shared types for the SCARV coprocessor writeback path: CPR address
// widths and the 40-bit queued write entry.
package scarv_cop_pkg;

  localparam int CPR_AW = 4;
  localparam int PAIR_W = 3;

  typedef struct packed {
    logic [CPR_AW-1:0] addr;
    logic [3:0]        ben;
    logic [31:0]       data;
  } wbq_entry_t;

endpackage

// File: rtl/scarv_cop_wbq_fifo.sv
// Generic DEPTH x 40-bit FIFO with per-entry valid bits and address taps,
// used as storage by the CPR writeback queue.
module scarv_cop_wbq_fifo
  import scarv_cop_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  wbq_entry_t                    push_entry_i,
  input  logic                          pop_i,
  output wbq_entry_t                    head_o,
  output logic [DEPTH-1:0]              valid_o,
  output logic [DEPTH-1:0][CPR_AW-1:0]  addr_o,
  output logic [CW-1:0]                 count_o
);

  wbq_entry_t       mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  // Push into a full queue or pop from an empty one is ignored here as a backstop.
  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    valid_d = valid_q;
    if (do_pop)  valid_d[rptr_q] = 1'b0;
    if (do_push) valid_d[wptr_q] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= push_entry_i;
  end

  always_comb begin
    for (int j = 0; j < DEPTH; j++) addr_o[j] = mem_q[j].addr;
  end

  assign head_o  = mem_q[rptr_q];
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/scarv_cop_wbq.sv
// CPR writeback queue: steers MALU pair writes, merges the auxiliary write
// source, drains into the CPR write port. Optional same-cycle bypass: SCARV_COP_WBQ_BYPASS_EN.
module scarv_cop_wbq
  import scarv_cop_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              malu_ivalid,
  input  logic              malu_idone,
  input  logic [PAIR_W-1:0] malu_crd,
  input  logic [3:0]        malu_cpr_rd_ben,
  input  logic [31:0]       malu_cpr_rd_wdata,
  input  logic              aux_wen,
  input  logic [CPR_AW-1:0] aux_waddr,
  input  logic [3:0]        aux_ben,
  input  logic [31:0]       aux_wdata,
  output logic              aux_ready,
  output logic              wbq_malu_ok,
  input  logic [11:0]       rd_addr,
  output logic [2:0]        wbq_hazard,
  input  logic              cpr_wgnt,
  output logic              cpr_wen,
  output logic [CPR_AW-1:0] cpr_waddr,
  output logic [3:0]        cpr_ben,
  output logic [31:0]       cpr_wdata,
  output logic              wbq_ovf
);

  localparam int CW = $clog2(DEPTH) + 1;

  wbq_entry_t                   malu_entry, aux_entry, in_entry, head;
  logic [DEPTH-1:0]             valid;
  logic [DEPTH-1:0][CPR_AW-1:0] addr_taps;
  logic [CW-1:0]                count, free_slots;
  logic                         malu_wr, full, empty, in_valid, bypass, push, pop;
  logic                         step_q, step_d, ovf_q, ovf_d;

  assign malu_wr = |malu_cpr_rd_ben;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  assign malu_entry = '{addr: {malu_crd, step_q}, ben: malu_cpr_rd_ben, data: malu_cpr_rd_wdata};
  assign aux_entry  = '{addr: aux_waddr, ben: aux_ben, data: aux_wdata};

  // MALU has priority; the aux source is also held off for a whole in-flight instruction.
  assign aux_ready = aux_wen && !malu_ivalid && !malu_wr && !full && !g_reset;
  assign in_valid  = malu_wr ? !full : aux_ready;
  assign in_entry  = malu_wr ? malu_entry : aux_entry;

`ifdef SCARV_COP_WBQ_BYPASS_EN
  assign bypass = in_valid && empty && cpr_wgnt && !g_reset;
`else
  assign bypass = 1'b0;
`endif

  assign push = in_valid && !bypass;
  assign pop  = cpr_wgnt && !empty;

  scarv_cop_wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (g_clk),
    .rst_i        (g_reset),
    .push_i       (push),
    .push_entry_i (in_entry),
    .pop_i        (pop),
    .head_o       (head),
    .valid_o      (valid),
    .addr_o       (addr_taps),
    .count_o      (count)
  );

  always_comb begin
    cpr_wen   = 1'b0;
    cpr_waddr = '0;
    cpr_ben   = '0;
    cpr_wdata = '0;
    if (pop) begin
      cpr_wen   = 1'b1;
      cpr_waddr = head.addr;
      cpr_ben   = head.ben;
      cpr_wdata = head.data;
    end else if (bypass) begin
      cpr_wen   = 1'b1;
      cpr_waddr = in_entry.addr;
      cpr_ben   = in_entry.ben;
      cpr_wdata = in_entry.data;
    end
  end

  // Step selects low/high register of the pair; idone overrides a same-cycle write.
  always_comb begin
    step_d = step_q;
    if (malu_wr)    step_d = 1'b1;
    if (malu_idone) step_d = 1'b0;
    ovf_d = ovf_q | (malu_wr && full);
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      step_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      step_q <= step_d;
      ovf_q  <= ovf_d;
    end
  end

  assign free_slots  = CW'(DEPTH) - count;
  assign wbq_malu_ok = (free_slots >= CW'(2));
  assign wbq_ovf     = ovf_q;

  always_comb begin
    wbq_hazard = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (valid[j] && (addr_taps[j] == rd_addr[4*i +: 4])) wbq_hazard[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scarv_cop_wbq.sv
// Scoreboard testbench for scarv_cop_wbq: expected CPR writes are queued as
// stimulus is accepted and compared when the DUT drives the write port.
module tb_scarv_cop_wbq;
  import scarv_cop_pkg::*;

  localparam int DEPTH = 4;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        malu_ivalid, malu_idone;
  logic [2:0]  malu_crd;
  logic [3:0]  malu_cpr_rd_ben;
  logic [31:0] malu_cpr_rd_wdata;
  logic        aux_wen;
  logic [3:0]  aux_waddr, aux_ben;
  logic [31:0] aux_wdata;
  logic        aux_ready, wbq_malu_ok;
  logic [11:0] rd_addr;
  logic [2:0]  wbq_hazard;
  logic        cpr_wgnt, cpr_wen;
  logic [3:0]  cpr_waddr, cpr_ben;
  logic [31:0] cpr_wdata;
  logic        wbq_ovf;

  wbq_entry_t sbQueue[$];
  logic       mStep;
  logic       mOvf;
  int         checkCount = 0;
  int         errorCount = 0;

  scarv_cop_wbq #(.DEPTH(DEPTH)) dut (
    .g_clk             (g_clk),
    .g_reset           (g_reset),
    .malu_ivalid       (malu_ivalid),
    .malu_idone        (malu_idone),
    .malu_crd          (malu_crd),
    .malu_cpr_rd_ben   (malu_cpr_rd_ben),
    .malu_cpr_rd_wdata (malu_cpr_rd_wdata),
    .aux_wen           (aux_wen),
    .aux_waddr         (aux_waddr),
    .aux_ben           (aux_ben),
    .aux_wdata         (aux_wdata),
    .aux_ready         (aux_ready),
    .wbq_malu_ok       (wbq_malu_ok),
    .rd_addr           (rd_addr),
    .wbq_hazard        (wbq_hazard),
    .cpr_wgnt          (cpr_wgnt),
    .cpr_wen           (cpr_wen),
    .cpr_waddr         (cpr_waddr),
    .cpr_ben           (cpr_ben),
    .cpr_wdata         (cpr_wdata),
    .wbq_ovf           (wbq_ovf)
  );

  always #5 g_clk = ~g_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [2:0] expHazard();
    logic [2:0] h = '0;
    for (int i = 0; i < 3; i++)
      foreach (sbQueue[k])
        if (sbQueue[k].addr == rd_addr[4*i +: 4]) h[i] = 1'b1;
    return h;
  endfunction

  // Drives one cycle of inputs, checks the DUT at the falling edge against the
  // reference model, then advances the model and the clock.
  task automatic applyStimulus(input logic iv, input logic id, input logic [2:0] crd,
                               input logic [3:0] mb, input logic [31:0] md,
                               input logic aw, input logic [3:0] aa, input logic [3:0] ab,
                               input logic [31:0] ad, input logic gnt);
    int         n;
    logic       mWr, isFull, auxRdy, accepted, bypassNow, expWen;
    wbq_entry_t inEntry, expEntry;
    malu_ivalid = iv;  malu_idone = id;  malu_crd = crd;
    malu_cpr_rd_ben = mb;  malu_cpr_rd_wdata = md;
    aux_wen = aw;  aux_waddr = aa;  aux_ben = ab;  aux_wdata = ad;
    cpr_wgnt = gnt;
    n        = sbQueue.size();
    isFull   = (n == DEPTH);
    mWr      = |mb;
    auxRdy   = aw && !iv && !mWr && !isFull;
    accepted = mWr ? !isFull : auxRdy;
    inEntry  = mWr ? '{addr: {crd, mStep}, ben: mb, data: md} : '{addr: aa, ben: ab, data: ad};
    @(negedge g_clk);
    checkOutput("aux_ready", aux_ready, auxRdy);
    checkOutput("wbq_malu_ok", wbq_malu_ok, (DEPTH - n) >= 2);
    checkOutput("wbq_ovf", wbq_ovf, mOvf);
    checkOutput("wbq_hazard", wbq_hazard, expHazard());
    bypassNow = 1'b0;
`ifdef SCARV_COP_WBQ_BYPASS_EN
    bypassNow = gnt && (n == 0) && accepted;
`endif
    if (gnt && n > 0) begin
      expEntry = sbQueue.pop_front();
      expWen   = 1'b1;
    end else if (bypassNow) begin
      expEntry = inEntry;
      expWen   = 1'b1;
    end else begin
      expEntry = '0;
      expWen   = 1'b0;
    end
    checkOutput("cpr_wen", cpr_wen, expWen);
    checkOutput("cpr_waddr", cpr_waddr, expEntry.addr);
    checkOutput("cpr_ben", cpr_ben, expEntry.ben);
    checkOutput("cpr_wdata", cpr_wdata, expEntry.data);
    if (mWr && isFull) mOvf = 1'b1;
    if (accepted && !bypassNow) sbQueue.push_back(inEntry);
    if (mWr) mStep = 1'b1;
    if (id)  mStep = 1'b0;
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle(input logic gnt);
    applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0, gnt);
  endtask

  task automatic auxWrite(input logic [3:0] aa, input logic [31:0] ad, input logic gnt);
    applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, aa, 4'hF, ad, gnt);
  endtask

  // Asserts reset with traffic still pending and checks the outputs are quiet immediately.
  task automatic doReset();
    g_reset = 1'b1;
    aux_wen = 1'b1;  aux_waddr = 4'd3;  aux_ben = 4'hF;  aux_wdata = 32'h5;
    cpr_wgnt = 1'b1;
    #1;
    checkOutput("rst_cpr_wen", cpr_wen, 1'b0);
    checkOutput("rst_cpr_waddr", cpr_waddr, 4'h0);
    checkOutput("rst_cpr_ben", cpr_ben, 4'h0);
    checkOutput("rst_cpr_wdata", cpr_wdata, 32'h0);
    checkOutput("rst_aux_ready", aux_ready, 1'b0);
    checkOutput("rst_hazard", wbq_hazard, 3'b000);
    checkOutput("rst_ovf", wbq_ovf, 1'b0);
    sbQueue.delete();
    mStep = 1'b0;
    mOvf  = 1'b0;
    aux_wen = 1'b0;  cpr_wgnt = 1'b0;
    @(negedge g_clk);
    g_reset = 1'b0;
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    g_reset = 1'b1;
    malu_ivalid = 0;  malu_idone = 0;  malu_crd = 0;  malu_cpr_rd_ben = 0;  malu_cpr_rd_wdata = 0;
    aux_wen = 0;  aux_waddr = 0;  aux_ben = 0;  aux_wdata = 0;
    cpr_wgnt = 0;  rd_addr = 12'h000;
    mStep = 1'b0;  mOvf = 1'b0;
    #2;
    doReset();

    $display("[TB] steering: pair 3 -> c6 then c7");
    applyStimulus(1'b1, 1'b0, 3'd3, 4'hF, 32'h11111111, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 3'd3, 4'hF, 32'h22222222, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("[TB] arbitration: aux held off during MALU instruction");
    applyStimulus(1'b1, 1'b0, 3'd1, 4'h0, 32'h0,        1'b1, 4'd5, 4'hF, 32'h55555555, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd1, 4'hF, 32'hAAAA0001, 1'b1, 4'd5, 4'hF, 32'h55555555, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd1, 4'h3, 32'hAAAA0002, 1'b1, 4'd5, 4'hF, 32'h55555555, 1'b0);
    auxWrite(4'd5, 32'h55555555, 1'b0);
    repeat (4) idle(1'b1);

    $display("[TB] full and overflow");
    for (int i = 0; i < DEPTH; i++) auxWrite(4'(i + 1), 32'hF000_0000 + 32'(i), 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd6, 4'hF, 32'hDEADBEEF, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
    auxWrite(4'd9, 32'h99, 1'b0);
    checkOutput("ovf_sticky", wbq_ovf, 1'b1);
    repeat (DEPTH + 1) idle(1'b1);
    checkOutput("ovf_held", wbq_ovf, 1'b1);

    doReset();
    $display("[TB] hazard against queued c9");
    rd_addr = {4'd2, 4'd9, 4'd9};
    auxWrite(4'd9, 32'h9999, 1'b0);
    idle(1'b0);
    checkOutput("hazard_c9", wbq_hazard, 3'b011);
    idle(1'b1);
    checkOutput("hazard_clear", wbq_hazard, 3'b000);
    rd_addr = 12'h000;

    $display("[TB] simultaneous enqueue/dequeue and pointer wrap");
    for (int i = 0; i < DEPTH - 1; i++) auxWrite(4'(i), 32'hC000_0000 + 32'(i), 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) auxWrite(4'(i + 4), 32'hB000_0000 + 32'(i), 1'b1);
    checkOutput("count_steady_ok", wbq_malu_ok, 1'b0);
    repeat (DEPTH) idle(1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      rd_addr = 12'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 3'($urandom),
                    ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom), $urandom,
                    1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), $urandom,
                    1'($urandom_range(0, 2) != 0));
    end
    repeat (DEPTH + 1) idle(1'b1);

    doReset();
    $display("[TB] reset mid-instruction");
    auxWrite(4'd1, 32'h0101, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd4, 4'hF, 32'h4444_0000, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
    rd_addr = {4'd8, 4'd1, 4'd8};
    idle(1'b0);
    doReset();
    applyStimulus(1'b1, 1'b1, 3'd4, 4'hF, 32'h4444_1111, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
    idle(1'b1);
    rd_addr = 12'h000;
    idle(1'b1);
    checkOutput("sb_drained", sbQueue.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/scarv_cop_wbq.md
Name: scarv_cop_wbq

Overview:
- CPR writeback queue, directly downstream of the multi-precision ALU.
- Consumes the ALU's per-cycle writeback words and steers the first write of an instruction to the low register of the destination pair and the second to the high register.
- Merges these writes with one auxiliary single-register write source into a small FIFO.
- Drains the FIFO into the single CPR write port and reports read-after-write hazards to the issue logic.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of two, minimum 2.

Ports:
- g_clk  in  1  global clock
- g_reset  in  1  asynchronous active-high reset
- malu_ivalid  in  1  MALU instruction in flight
- malu_idone  in  1  MALU instruction completes this cycle
- malu_crd  in  3  destination pair index; registers {malu_crd,0} and {malu_crd,1}
- malu_cpr_rd_ben  in  4  MALU writeback byte enables; any bit set = write
- malu_cpr_rd_wdata  in  32  MALU writeback data
- aux_wen  in  1  auxiliary write request
- aux_waddr  in  4  auxiliary destination CPR
- aux_ben  in  4  auxiliary byte enables
- aux_wdata  in  32  auxiliary data
- aux_ready  out  1  auxiliary write accepted this cycle
- wbq_malu_ok  out  1  at least 2 free entries; issue may start a MALU instruction
- rd_addr  in  12  three 4-bit CPR read addresses {rs3,rs2,rs1}
- wbq_hazard  out  3  bit i set: a queued entry targets rd_addr[4i+3:4i]
- cpr_wgnt  in  1  CPR write port granted this cycle
- cpr_wen  out  1  CPR write strobe
- cpr_waddr  out  4  CPR write address
- cpr_ben  out  4  CPR write byte enables
- cpr_wdata  out  32  CPR write data
- wbq_ovf  out  1  sticky overflow flag

Behaviour:
- Reset (async, any time, including mid-instruction):
  - all entries invalidated, pointers and count to 0, step to 0, wbq_ovf to 0.
  - Outputs: cpr_wen=0, cpr_waddr=0, cpr_ben=0, cpr_wdata=0, wbq_hazard=0, aux_ready=0 while reset is asserted, wbq_malu_ok=1 after reset.
- MALU write (malu_wr): any bit of malu_cpr_rd_ben set.
  - Target address is {malu_crd, step}.
  - On malu_wr, step is set to 1.
  - On malu_idone, step is cleared; idone wins over the set.
  - A write in the idone cycle uses the pre-update step.
- Enqueue source: at most one enqueue per cycle, MALU has priority.
  - aux_ready = aux_wen && !malu_ivalid && !malu_wr && !full.
  - aux_ready never depends on cpr_wgnt.
- Dequeue: when cpr_wgnt && !empty, the head entry drives cpr_wen/waddr/ben/wdata combinationally and is popped at the clock edge. Otherwise cpr_wen=0 and the data outputs are 0.
- Enqueue and dequeue in the same cycle are legal. full and empty are evaluated on the current count. Count is unchanged when both occur.
- Overflow: malu_wr while full is dropped and sets wbq_ovf, which holds until reset. Entries are never overwritten.
- wbq_malu_ok = (DEPTH - count) >= 2.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Hazard: compare against valid entries only, combinational; incoming and bypassed writes are excluded. Byte enables are ignored (address match only).
- Ordering: strict FIFO. The CPR writes of one MALU instruction appear low register then high register.

Optional Feature:
- Macro: SCARV_COP_WBQ_BYPASS_EN.
- Defined: when the queue is empty and cpr_wgnt=1, the accepted incoming write (MALU, else auxiliary) drives the CPR port in the same cycle and is not enqueued. Zero-cycle latency.
- Undefined: every write is enqueued. The earliest CPR write is the cycle after acceptance.

Decomposition:
- Shared package scarv_cop_pkg:
  - CPR address width (4)
  - pair index width (3)
  - entry struct {addr[3:0], ben[3:0], data[31:0]}
- Sub-module scarv_cop_wbq_fifo: generic DEPTH×40-bit storage with valid bits and per-entry address taps for the hazard compare. Steering, arbitration and step tracking stay in the top module.

Test Plan:
- Steering: malu_crd=3; ben=F with data 0x11111111, next cycle 0x22222222 with idone; cpr_wgnt=1 → CPR writes c6=0x11111111 then c7=0x22222222 (c6 one cycle earlier with bypass), step back to 0.
- Arbitration: aux_wen=1 addr 5 while malu_ivalid=1 → aux_ready=0 until malu_ivalid drops, then the c5 write follows the MALU pair.
- Full/overflow: cpr_wgnt=0, DEPTH=4; 4 aux writes fill the queue (wbq_malu_ok=0 after 3); a MALU write → dropped, wbq_ovf=1; grant restores draining in FIFO order.
- Hazard: queue holds c9; rd_addr={4'd2,4'd9,4'd9} → wbq_hazard=3'b011; after c9 drains → 3'b000.
- Simultaneous: count=DEPTH-1, enqueue and dequeue in one cycle → count unchanged, no ovf; pointer wrap over ≥2·DEPTH writes preserves data.
- Reset mid-instruction: assert g_reset after the low-word write with 2 entries queued → cpr_wen=0 immediately, queue empty, next MALU write targets the low register.
